// File: rtl/dds_pkg.sv
// Shared definitions for the dds block and its sweep controller.
package dds_pkg;

  localparam int unsigned KW_DEF = 32;
  localparam int unsigned DW_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } sweep_state_e;

endpackage

// File: rtl/dwell_timer.sv
// Down-counter that times how long each control word is held; zero_o flags the
// last dwell cycle and is registered alongside the count.
module dwell_timer
  import dds_pkg::*;
#(
  parameter int unsigned DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic [DW-1:0] load_val_i,
  input  logic          dec_i,
  input  logic          freeze_i,
  output logic          zero_o
);

  logic [DW-1:0] cnt_q;
  logic [DW-1:0] cnt_d;

  // Load has priority; freeze holds the count while paused.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && !freeze_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - DW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      zero_o <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      zero_o <= (cnt_d == '0);
    end
  end

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer: steps the dds control word from k_start to k_stop,
// holding each word for a programmable dwell, with pause, abort and repeat.
module dds_sweep_ctrl
  import dds_pkg::*;
#(
  parameter int unsigned KW = KW_DEF,
  parameter int unsigned DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic          pause,
  input  logic          cont,
  input  logic [KW-1:0] k_start,
  input  logic [KW-1:0] k_stop,
  input  logic [KW-1:0] k_step,
  input  logic [DW-1:0] dwell,
  output logic [KW-1:0] K,
  output logic          Ken,
  output logic          dds_en,
  output logic          busy,
  output logic          done
);

  sweep_state_e state_q, state_d;

  logic [KW-1:0] k_q, k_d;
  logic          ken_q, ken_d;
  logic          en_q, en_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [KW-1:0] start_q, stop_q, step_q;
  logic          cont_q;
  logic [DW-1:0] dm1_q;

  logic          start_ok_c;
  logic [DW-1:0] dm1_in_c;
  logic [KW:0]   next_c;
  logic          step_ok_c;

  logic          tmr_load, tmr_dec, tmr_freeze, tmr_zero;
  logic [DW-1:0] tmr_val;

  assign start_ok_c = (state_q == ST_IDLE) && start && !abort;
  // A dwell of 0 behaves as 1, so the reload value saturates at 0.
  assign dm1_in_c   = (dwell == '0) ? '0 : (dwell - DW'(1));
  assign next_c     = {1'b0, k_q} + {1'b0, step_q};
  assign step_ok_c  = !next_c[KW] && (next_c[KW-1:0] <= stop_q) && (step_q != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q <= '0;
      stop_q  <= '0;
      step_q  <= '0;
      cont_q  <= 1'b0;
      dm1_q   <= '0;
    end else if (start_ok_c) begin
      start_q <= k_start;
      stop_q  <= k_stop;
      step_q  <= k_step;
      cont_q  <= cont;
      dm1_q   <= dm1_in_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_ok_c) state_d = ST_RUN;
      end
      ST_RUN, ST_PAUSE: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (pause) begin
          state_d = ST_PAUSE;
        end else if (tmr_zero && !step_ok_c && !cont_q) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Next values for the registered outputs and the dwell timer controls.
  always_comb begin
    k_d        = k_q;
    ken_d      = 1'b0;
    en_d       = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    tmr_load   = 1'b0;
    tmr_dec    = 1'b0;
    tmr_freeze = 1'b0;
    tmr_val    = dm1_q;
    case (state_q)
      ST_IDLE: begin
        if (start_ok_c) begin
          k_d      = k_start;
          ken_d    = 1'b1;
          en_d     = 1'b1;
          busy_d   = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = dm1_in_c;
        end
      end
      ST_RUN, ST_PAUSE: begin
        if (abort) begin
          k_d = k_q;
        end else if (pause) begin
          busy_d     = 1'b1;
          tmr_freeze = 1'b1;
        end else begin
          busy_d  = 1'b1;
          en_d    = 1'b1;
          tmr_dec = 1'b1;
          if (tmr_zero) begin
            if (step_ok_c) begin
              k_d      = next_c[KW-1:0];
              ken_d    = 1'b1;
              tmr_load = 1'b1;
            end else if (cont_q) begin
              k_d      = start_q;
              ken_d    = 1'b1;
              tmr_load = 1'b1;
            end else begin
              busy_d = 1'b0;
              en_d   = 1'b0;
              done_d = 1'b1;
            end
          end
        end
      end
      default: begin
        k_d = k_q;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q    <= '0;
      ken_q  <= 1'b0;
      en_q   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      k_q    <= k_d;
      ken_q  <= ken_d;
      en_q   <= en_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  dwell_timer #(
    .DW(DW)
  ) u_dwell_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .dec_i      (tmr_dec),
    .freeze_i   (tmr_freeze),
    .zero_o     (tmr_zero)
  );

  assign K      = k_q;
  assign Ken    = ken_q;
  assign dds_en = en_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed, table-driven bench for dds_sweep_ctrl with hand sequences for
// pause and asynchronous reset.
module tb_dds_sweep_ctrl;

  localparam int unsigned KW = 32;
  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, abort, pause, cont;
  logic [KW-1:0] k_start, k_stop, k_step;
  logic [DW-1:0] dwell;
  logic [KW-1:0] K;
  logic          Ken, dds_en, busy, done;

  typedef struct {
    logic          st, ab, pa, co;
    logic [KW-1:0] ks, kp, kst;
    logic [DW-1:0] dw;
    logic [KW-1:0] e_k;
    logic          e_ken, e_en, e_busy, e_done;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;

  dds_sweep_ctrl #(.KW(KW), .DW(DW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .abort   (abort),
    .pause   (pause),
    .cont    (cont),
    .k_start (k_start),
    .k_stop  (k_stop),
    .k_step  (k_step),
    .dwell   (dwell),
    .K       (K),
    .Ken     (Ken),
    .dds_en  (dds_en),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  function automatic void add(input logic st, input logic ab, input logic pa, input logic co,
                              input logic [KW-1:0] ks, input logic [KW-1:0] kp,
                              input logic [KW-1:0] kst, input logic [DW-1:0] dw,
                              input logic [KW-1:0] e_k, input logic e_ken, input logic e_en,
                              input logic e_busy, input logic e_done);
    vec_t v;
    v.st = st; v.ab = ab; v.pa = pa; v.co = co;
    v.ks = ks; v.kp = kp; v.kst = kst; v.dw = dw;
    v.e_k = e_k; v.e_ken = e_ken; v.e_en = e_en; v.e_busy = e_busy; v.e_done = e_done;
    tbl.push_back(v);
  endfunction

  // Expected outputs c cycles after the start edge of the 100/50/200, dwell 3 sweep.
  task automatic basic_exp(input int c, output logic [KW-1:0] e_k, output logic e_ken,
                           output logic e_en, output logic e_busy, output logic e_done);
    e_k    = (c <= 3) ? 32'd100 : (c <= 6) ? 32'd150 : 32'd200;
    e_ken  = (c == 1) || (c == 4) || (c == 7);
    e_en   = (c <= 9);
    e_busy = (c <= 9);
    e_done = (c == 10);
  endtask

  task automatic cyc(input logic st, input logic ab, input logic pa, input logic co,
                     input logic [KW-1:0] ks, input logic [KW-1:0] kp,
                     input logic [KW-1:0] kst, input logic [DW-1:0] dw);
    @(negedge clk);
    start = st; abort = ab; pause = pa; cont = co;
    k_start = ks; k_stop = kp; k_step = kst; dwell = dw;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input int id, input logic [KW-1:0] e_k, input logic e_ken,
                       input logic e_en, input logic e_busy, input logic e_done);
    n_vec++;
    if (K !== e_k || Ken !== e_ken || dds_en !== e_en || busy !== e_busy || done !== e_done) begin
      n_bad++;
      $display("FAIL vec %0d: got K=%h Ken=%b en=%b busy=%b done=%b, want K=%h Ken=%b en=%b busy=%b done=%b",
               id, K, Ken, dds_en, busy, done, e_k, e_ken, e_en, e_busy, e_done);
    end
  endtask

  initial begin
    logic [KW-1:0] ek;
    logic ekn, een, eb, ed;

    // Basic sweep; junk config after start must be ignored.
    for (int c = 1; c <= 11; c++) begin
      basic_exp(c, ek, ekn, een, eb, ed);
      if (c == 1) add(1, 0, 0, 0, 100, 200, 50, 3, ek, ekn, een, eb, ed);
      else        add(0, 0, 0, 1, 7, 9, 1, 2, ek, ekn, een, eb, ed);
    end
    // Overflow ends the sweep without ever presenting a wrapped word.
    add(1, 0, 0, 0, 32'hFFFF_FF00, 32'hFFFF_FFFF, 32'h100, 0, 32'hFFFF_FF00, 1, 1, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 32'hFFFF_FF00, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 32'hFFFF_FF00, 0, 0, 0, 0);
    // Abort beats start in IDLE; abort alone in IDLE does nothing.
    add(1, 1, 0, 0, 100, 200, 50, 3, 32'hFFFF_FF00, 0, 0, 0, 0);
    add(0, 1, 0, 0, 100, 200, 50, 3, 32'hFFFF_FF00, 0, 0, 0, 0);
    // Start while busy is ignored.
    for (int c = 1; c <= 10; c++) begin
      basic_exp(c, ek, ekn, een, eb, ed);
      if (c == 1)      add(1, 0, 0, 0, 100, 200, 50, 3, ek, ekn, een, eb, ed);
      else if (c == 2) add(1, 0, 0, 1, 500, 1000, 7, 1, ek, ekn, een, eb, ed);
      else             add(0, 0, 0, 0, 100, 200, 50, 3, ek, ekn, een, eb, ed);
    end
    // Continuous mode, started in the done cycle, then aborted.
    for (int c = 1; c <= 10; c++) begin
      ek  = ((c - 1) / 3 % 3 == 0) ? 32'd100 : ((c - 1) / 3 % 3 == 1) ? 32'd150 : 32'd200;
      ekn = ((c - 1) % 3 == 0);
      if (c == 1) add(1, 0, 0, 1, 100, 200, 50, 3, ek, ekn, 1, 1, 0);
      else        add(0, 0, 0, 0, 9, 9, 9, 9, ek, ekn, 1, 1, 0);
    end
    add(0, 1, 0, 0, 0, 0, 0, 0, 32'd100, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 32'd100, 0, 0, 0, 0);

    rst_n = 1'b0;
    start = 0; abort = 0; pause = 0; cont = 0;
    k_start = '0; k_stop = '0; k_step = '0; dwell = '0;
    #12;
    check(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].st, tbl[i].ab, tbl[i].pa, tbl[i].co, tbl[i].ks, tbl[i].kp, tbl[i].kst, tbl[i].dw);
      check(i + 1, tbl[i].e_k, tbl[i].e_ken, tbl[i].e_en, tbl[i].e_busy, tbl[i].e_done);
    end

    // Pause for 5 edges mid-dwell with dwell 6: next word moves from cycle 7 to 12.
    cyc(1, 0, 0, 0, 100, 200, 50, 6);
    check(1001, 100, 1, 1, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    check(1002, 100, 0, 1, 1, 0);
    for (int c = 3; c <= 7; c++) begin
      cyc(0, 0, 1, 0, 0, 0, 0, 0);
      check(1000 + c, 100, 0, 0, 1, 0);
    end
    for (int c = 8; c <= 11; c++) begin
      cyc(0, 0, 0, 0, 0, 0, 0, 0);
      check(1000 + c, 100, 0, 1, 1, 0);
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    check(1012, 150, 1, 1, 1, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 0);
    check(1013, 150, 0, 0, 0, 0);

    // Asynchronous reset mid-sweep, then a clean sweep afterwards.
    for (int c = 1; c <= 5; c++) begin
      cyc(c == 1, 0, 0, 0, 100, 200, 50, 3);
    end
    check(2000, 150, 0, 1, 1, 0);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check(2001, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      cyc(c == 1, 0, 0, 0, 100, 200, 50, 3);
      basic_exp(c, ek, ekn, een, eb, ed);
      check(2001 + c, ek, ekn, een, eb, ed);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/dds_sweep_ctrl.md
# dds_sweep_ctrl

Frequency-sweep sequencer driving the control inputs of the `dds` phase-accumulator/ROM block. On a start pulse it latches a sweep configuration and steps the frequency control word from `k_start` to `k_stop` in `k_step` increments. Each word is held for a programmable dwell time; the sweep optionally repeats. It owns `K`, `Ken` and `dds_en` of the downstream `dds`, and reports progress to the host logic through `busy` and `done`.

## Interface
Parameters:
- `KW`, 32, frequency-control-word width; must match `dds` `K` width.
- `DW`, 16, dwell counter width.

Ports:
- `clk`  in  1  system clock, the same clock as `dds`.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a sweep; ignored while `busy`.
- `abort`  in  1  terminate the sweep immediately; wins over `start`.
- `pause`  in  1  level; freezes the sweep and the accumulator while high in RUN.
- `cont`  in  1  sampled at start; 1 means repeat the sweep until aborted.
- `k_start`  in  KW  first control word.
- `k_stop`  in  KW  last permitted control word (inclusive).
- `k_step`  in  KW  increment per step.
- `dwell`  in  DW  cycles per word; 0 is treated as 1.
- `K`  out  KW  control word to `dds`.
- `Ken`  out  1  one-cycle load strobe to `dds`.
- `dds_en`  out  1  accumulator enable to `dds`.
- `busy`  out  1  high in RUN and PAUSE.
- `done`  out  1  one-cycle pulse on normal sweep completion.

## Operation
- States: IDLE, RUN, PAUSE. Reset state is IDLE.
- **IDLE + `start` (and not `abort`):**
  - Latch `k_start`, `k_stop`, `k_step`, `cont` and D = max(`dwell`,1) into shadow registers.
  - Set `K`=`k_start` and `Ken`=1. Go to RUN.
  - Load the dwell counter with D-1.
  - Input changes after this point have no effect until the next start.
- **RUN:**
  - `dds_en`=1. The counter decrements each cycle.
  - When the counter is 0, compute next = `K`+`k_step` in KW+1 bits.
  - If next ≤ `k_stop` with no carry, and `k_step`≠0: `K`←next, `Ken`=1, reload the counter with D-1.
  - Otherwise the end of the sweep is reached:
    - If `cont`: `K`←`k_start`, `Ken`=1, reload the counter.
    - Else: go to IDLE, `done`=1, `dds_en`=0.
  - `k_start` > `k_stop` produces exactly one dwell at `k_start`, then the end-of-sweep path.
- **`pause` high in RUN:**
  - Go to PAUSE with the counter frozen and `dds_en`=0. `K` is held and no `Ken` is issued.
  - `pause` low returns to RUN, and the counter resumes from the frozen value.
- **`abort` in RUN or PAUSE:**
  - Go to IDLE next cycle with `dds_en`=0, `Ken`=0, `busy`=0, no `done`.
  - `K` holds its last value.
- `start` while `busy`: ignored.
- `abort` in IDLE: no effect.
- `start` and `abort` in the same cycle: abort wins and the sweep does not start.

## Timing
- All outputs are registered.
- Reset values: `K`=0, `Ken`=0, `dds_en`=0, `busy`=0, `done`=0. The shadow registers and counter reset to 0.
- **Start latency:** `start` sampled at edge t, then `K`=`k_start`, `Ken`=1, `busy`=1, `dds_en`=1 from cycle t+1.
- **Word spacing:** in RUN without pause, `Ken` pulses are exactly D cycles apart. Each word is presented for D cycles, counting the `Ken` cycle.
- **Pause:** each paused cycle extends the current word by one cycle. `pause` asserted in the `Ken` cycle still lets that strobe complete, since it was already registered.
- **Completion:** `done`=1 and `busy`=0 in the cycle after the last word's final dwell cycle. `done` lasts exactly 1 cycle.
- **Restart:** a new `start` is accepted in the same cycle `done` is high.
- **Wrap-around:** none. Arithmetic overflow is treated as end of sweep; `K` never wraps.
- Reset asserted mid-sweep forces all outputs to reset values asynchronously.

## Structure
- Shared package `dds_pkg`:
  - state enum (IDLE/RUN/PAUSE);
  - default `KW`/`DW` constants, reused by `dds` integrations.
- Sub-module `dwell_timer`:
  - inputs: load (value D-1), decrement enable, freeze;
  - output: a `zero` flag.
- The FSM, the step adder and the compare live in `dds_sweep_ctrl`.

## Test plan
- **Basic sweep:** `k_start`=100, `k_step`=50, `k_stop`=200, `dwell`=3, `cont`=0.
  - Required: `Ken` at cycles 1, 4, 7 with K=100/150/200.
  - `done` at cycle 10; `busy` is 1 for cycles 1–9.
- **Overflow:** `k_start`=0xFFFF_FF00, `k_step`=0x100, `k_stop`=0xFFFF_FFFF, `dwell`=0.
  - Required: K=0xFFFF_FF00 for one cycle, then `done`; no K=0.
- **Continuous mode:** values as basic sweep with `cont`=1, run 3 periods, then `abort`.
  - Required: K sequence 100,150,200,100,…
  - After abort: `busy`/`dds_en` are 0 next cycle, no `done`, K holds.
- **Pause:** `pause` held 5 cycles mid-dwell.
  - Required: `dds_en`=0 for those 5 cycles, no `Ken`, and the next `Ken` is delayed by exactly 5 cycles.
- **Simultaneous events:**
  - `start`+`abort` together in IDLE: no start.
  - `start` while `busy` with different `k_start`: ignored, and the sequence is unchanged.
- **Async reset mid-sweep:** all outputs are 0 immediately; the next `start` after release runs a clean sweep.
